// File: rtl/dac_instr_queue.sv
// Per-channel DAC code queue feeding an 8-channel serial DAC: keeps the latest code per
// channel, sends a reference-enable frame after reset, then services pending channels round-robin.
module dac_instr_queue #(
  parameter int N_CHAN = 8,
  parameter int W_DATA = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [W_DATA-1:0] data_in,
  input  logic [2:0]        chan_in,
  input  logic              dv_in,
  input  logic              clr_in,
  output logic              dac_nsync_out,
  output logic              dac_sclk_out,
  output logic              dac_din_out,
  output logic              dac_nldac_out,
  output logic              dac_nclr_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [2:0]        done_chan_out
);

  // state | meaning
  // INIT  | first cycle out of reset, loads the reference frame
  // IDLE  | waiting for a pending channel or a latched clear
  // SHIFT | 64 cycles, 32 bits at clk/2
  // GAP   | 2 cycles with nsync high
  // LDAC  | 2 cycles with nldac low (data frames only)
  // CLR   | 4 cycles with nclr low
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SHIFT, S_GAP, S_LDAC, S_CLR} state_t;

  localparam logic [31:0] REF_FRAME = 32'h0800_0001;

  state_t            r_state, w_state_nxt;
  logic [5:0]        r_cnt, w_cnt_nxt;
  logic [31:0]       r_shreg, w_shreg_nxt;
  logic              r_ref;
  logic [W_DATA-1:0] r_code [N_CHAN];
  logic [N_CHAN-1:0] r_pend, w_pend_nxt;
  logic              r_clr_pend;
  logic [2:0]        r_last, w_sel;
  logic              w_found, w_start, w_clr_entry, w_dv_ok;
  logic [3:0]        w_idx;

  logic r_nsync, r_sclk, r_din, r_nldac, r_nclr, r_busy, r_done;
  logic [2:0] r_done_chan;
  logic w_nsync_nxt, w_sclk_nxt, w_din_nxt, w_nldac_nxt, w_nclr_nxt, w_busy_nxt, w_done_nxt;

  assign w_dv_ok     = dv_in && (32'(chan_in) < N_CHAN);
  assign w_start     = (r_state == S_IDLE) && !r_clr_pend && (|r_pend);
  assign w_clr_entry = (r_state == S_IDLE) && r_clr_pend;

  // round-robin: first pending channel strictly after the last serviced one
  always_comb begin
    w_sel   = r_last;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N_CHAN; k++) begin
      w_idx = {1'b0, r_last} + 4'(k);
      if (w_idx >= 4'(N_CHAN)) w_idx = w_idx - 4'(N_CHAN);
      if (!w_found && r_pend[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[2:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        w_state_nxt = S_SHIFT;
        w_cnt_nxt   = 6'd63;
      end
      S_IDLE: begin
        if (r_clr_pend) begin
          w_state_nxt = S_CLR;
          w_cnt_nxt   = 6'd3;
        end else if (|r_pend) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = 6'd63;
        end
      end
      S_SHIFT: begin
        if (r_cnt == 6'd0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = 6'd1;
        end else w_cnt_nxt = r_cnt - 6'd1;
      end
      S_GAP: begin
        if (r_cnt == 6'd0) begin
          w_state_nxt = r_ref ? S_IDLE : S_LDAC;
          w_cnt_nxt   = 6'd1;
        end else w_cnt_nxt = r_cnt - 6'd1;
      end
      S_LDAC, S_CLR: begin
        if (r_cnt == 6'd0) w_state_nxt = S_IDLE;
        else w_cnt_nxt = r_cnt - 6'd1;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    w_shreg_nxt = r_shreg;
    if (r_state == S_INIT) w_shreg_nxt = REF_FRAME;
    else if (w_start) w_shreg_nxt = {8'h00, 1'b0, w_sel, r_code[w_sel], 4'h0};
    else if (r_state == S_SHIFT && r_cnt != 6'd0 && !r_cnt[0]) w_shreg_nxt = {r_shreg[30:0], 1'b0};

    w_pend_nxt = r_pend;
    if (w_start) w_pend_nxt[w_sel] = 1'b0;
    if (w_clr_entry) w_pend_nxt = '0;
    if (w_dv_ok) w_pend_nxt[chan_in] = 1'b1;
  end

  // Output values for the next cycle, registered below.
  always_comb begin
    w_nsync_nxt = (w_state_nxt != S_SHIFT);
    w_sclk_nxt  = (w_state_nxt == S_SHIFT) ? w_cnt_nxt[0] : 1'b1;
    w_din_nxt   = (w_state_nxt == S_SHIFT) ? w_shreg_nxt[31] : 1'b0;
    w_nldac_nxt = (w_state_nxt != S_LDAC);
    w_nclr_nxt  = (w_state_nxt != S_CLR);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (r_state == S_LDAC) && (r_cnt == 6'd0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_ref       <= 1'b1;
      r_pend      <= '0;
      r_clr_pend  <= 1'b0;
      r_last      <= 3'(N_CHAN - 1);
      for (int i = 0; i < N_CHAN; i++) r_code[i] <= '0;
      r_nsync     <= 1'b1;
      r_sclk      <= 1'b1;
      r_din       <= 1'b0;
      r_nldac     <= 1'b1;
      r_nclr      <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_done_chan <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_pend  <= w_pend_nxt;
      if (r_state == S_INIT) r_ref <= 1'b1;
      else if (w_start) r_ref <= 1'b0;
      if (w_start) r_last <= w_sel;
      if (w_dv_ok) r_code[chan_in] <= data_in;
      if (clr_in) r_clr_pend <= 1'b1;
      else if (w_clr_entry) r_clr_pend <= 1'b0;
      r_nsync <= w_nsync_nxt;
      r_sclk  <= w_sclk_nxt;
      r_din   <= w_din_nxt;
      r_nldac <= w_nldac_nxt;
      r_nclr  <= w_nclr_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_done_nxt) r_done_chan <= r_last;
    end
  end

  assign dac_nsync_out = r_nsync;
  assign dac_sclk_out  = r_sclk;
  assign dac_din_out   = r_din;
  assign dac_nldac_out = r_nldac;
  assign dac_nclr_out  = r_nclr;
  assign busy_out      = r_busy;
  assign done_out      = r_done;
  assign done_chan_out = r_done_chan;

endmodule
